mem_stage: RTL and testbench

//  MEM stage of the 20-bit MIPS pipeline; consumes the EX/MEM register outputs directly.

---
 rtl/mem_stage_pkg.sv | 14 +
 rtl/mem_wb_reg.sv | 39 +++
 rtl/mem_stage.sv | 135 +++++++++++++
 tb/tb_mem_stage.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths and FSM encoding for the MEM stage
package mem_stage_pkg;

    localparam int DW_DEF      = 20;
    localparam int AW_DEF      = 20;
    localparam int RW_DEF      = 20;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register, loads a zeroed bubble while bubble=1
module mem_wb_reg
    import mem_stage_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bubble,
    input  logic          regwrite,
    input  logic          memtoreg,
    input  logic [RW-1:0] write_destination,
    input  logic [DW-1:0] alu_output,
    input  logic [DW-1:0] mem_data,
    output logic          wb_regwrite,
    output logic          wb_memtoreg,
    output logic [RW-1:0] wb_write_destination,
    output logic [DW-1:0] wb_alu_output,
    output logic [DW-1:0] wb_mem_data
);

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            wb_regwrite          <= 1'b0;
            wb_memtoreg          <= 1'b0;
            wb_write_destination <= '0;
            wb_alu_output        <= '0;
            wb_mem_data          <= '0;
        end else begin
            wb_regwrite          <= regwrite;
            wb_memtoreg          <= memtoreg;
            wb_write_destination <= write_destination;
            wb_alu_output        <= alu_output;
            wb_mem_data          <= mem_data;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM stage: data-memory FSM with timeout, next-PC resolve, MEM/WB drive
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF,
    parameter int RW      = RW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [RW-1:0] write_destination,
    input  logic          zero_flaf,
    input  logic [DW-1:0] alu_output,
    input  logic [DW-1:0] result_shift_jump,
    input  logic [DW-1:0] result_adder_branch,
    input  logic [DW-1:0] read_data2,
    input  logic [DW-1:0] output_adder_increment_pc,
    input  logic          memwrite,
    input  logic          memread,
    input  logic          branch,
    input  logic          j,
    input  logic          jmem,
    input  logic          stw,
    input  logic          regwrite,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_ack,
    output logic          stall,
    output logic          pc_load,
    output logic [DW-1:0] pc_target,
    output logic          wb_regwrite,
    output logic          wb_memtoreg,
    output logic [RW-1:0] wb_write_destination,
    output logic [DW-1:0] wb_alu_output,
    output logic [DW-1:0] wb_mem_data,
    output logic          mem_err
);

    localparam int            CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          mem_op, illegal, in_req, ack_done, timed_out, retire, op_ok;

    assign mem_op    = memread | memwrite | jmem;
    assign illegal   = memwrite & (memread | jmem);
    assign in_req    = (state == ST_REQ);
    assign ack_done  = in_req & dmem_ack;
    // An ack on the final allowed cycle takes precedence over the abort.
    assign timed_out = in_req & ~dmem_ack & (cnt == LAST);
    assign retire    = ~rst & ((~in_req & ~mem_op) | ack_done | timed_out);
    assign stall     = ~rst & ~retire;
    assign op_ok     = retire & ~timed_out;

    always_comb begin
        pc_load   = 1'b0;
        pc_target = '0;
        if (op_ok) begin
            if (jmem) begin
                pc_load   = 1'b1;
                pc_target = dmem_rdata;
            end else if (j) begin
                pc_load   = 1'b1;
                pc_target = result_shift_jump;
            end else if (branch && zero_flaf) begin
                pc_load   = 1'b1;
                pc_target = result_adder_branch;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            mem_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_op) begin
                        state      <= ST_REQ;
                        cnt        <= '0;
                        dmem_req   <= 1'b1;
                        dmem_we    <= memwrite & ~illegal;
                        dmem_addr  <= alu_output[AW-1:0];
                        dmem_wdata <= stw ? output_adder_increment_pc : read_data2;
                        if (illegal)
                            mem_err <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (ack_done || timed_out) begin
                        state      <= ST_IDLE;
                        cnt        <= '0;
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        dmem_addr  <= '0;
                        dmem_wdata <= '0;
                        if (timed_out)
                            mem_err <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mem_wb_reg #(.DW(DW), .RW(RW)) u_mem_wb (
        .clk                  (clk),
        .rst                  (rst),
        .bubble               (stall),
        .regwrite             (regwrite & ~timed_out),
        .memtoreg             (memread & ~jmem),
        .write_destination    (write_destination),
        .alu_output           (alu_output),
        .mem_data             (ack_done ? dmem_rdata : '0),
        .wb_regwrite          (wb_regwrite),
        .wb_memtoreg          (wb_memtoreg),
        .wb_write_destination (wb_write_destination),
        .wb_alu_output        (wb_alu_output),
        .wb_mem_data          (wb_mem_data)
    );

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized op-level reference check of mem_stage
module tb_mem_stage;

    localparam int DW = 20;
    localparam int AW = 20;
    localparam int RW = 20;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] write_destination;
    logic          zero_flaf;
    logic [DW-1:0] alu_output, result_shift_jump, result_adder_branch, read_data2;
    logic [DW-1:0] output_adder_increment_pc;
    logic          memwrite, memread, branch, j, jmem, stw, regwrite;
    logic          dmem_req, dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata, dmem_rdata;
    logic          dmem_ack, stall, pc_load;
    logic [DW-1:0] pc_target;
    logic          wb_regwrite, wb_memtoreg;
    logic [RW-1:0] wb_write_destination;
    logic [DW-1:0] wb_alu_output, wb_mem_data;
    logic          mem_err;

    always #5 clk = ~clk;

    mem_stage #(.DW(DW), .AW(AW), .RW(RW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .write_destination(write_destination), .zero_flaf(zero_flaf),
        .alu_output(alu_output), .result_shift_jump(result_shift_jump),
        .result_adder_branch(result_adder_branch), .read_data2(read_data2),
        .output_adder_increment_pc(output_adder_increment_pc),
        .memwrite(memwrite), .memread(memread), .branch(branch), .j(j), .jmem(jmem),
        .stw(stw), .regwrite(regwrite), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .stall(stall), .pc_load(pc_load), .pc_target(pc_target),
        .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
        .wb_write_destination(wb_write_destination), .wb_alu_output(wb_alu_output),
        .wb_mem_data(wb_mem_data), .mem_err(mem_err)
    );

    typedef struct {
        logic          mr, mw, jm, st, rw, br, jp, zf;
        logic [RW-1:0] dst;
        logic [DW-1:0] alu, sj, ab, rd2, pc1, rdata;
        int            wt;   // ack on REQ cycle wt+1; negative or >=TO means never
    } op_t;

    typedef struct {
        logic          rw, mtr;
        logic [RW-1:0] dst;
        logic [DW-1:0] alu, md;
    } wb_t;

    int            total = 0, bad = 0;
    int            stall_cnt = 0, pl_cnt = 0, cyc = 0;
    logic [DW-1:0] last_tgt = '0, seen_wd = '0;
    logic          seen_we = 1'b0;
    bit            chk_en = 1'b0;

    logic          e_stall, e_pcl, e_req, e_we, e_err, p_err;
    logic [DW-1:0] e_tgt, e_wd;
    logic [AW-1:0] e_addr;
    wb_t           e_wb, p_wb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        chk("stall",      32'(stall),                32'(e_stall));
        chk("pc_load",    32'(pc_load),              32'(e_pcl));
        chk("pc_target",  32'(pc_target),            32'(e_tgt));
        chk("dmem_req",   32'(dmem_req),             32'(e_req));
        chk("dmem_we",    32'(dmem_we),              32'(e_we));
        chk("dmem_addr",  32'(dmem_addr),            32'(e_addr));
        chk("dmem_wdata", 32'(dmem_wdata),           32'(e_wd));
        chk("wb_regw",    32'(wb_regwrite),          32'(e_wb.rw));
        chk("wb_mtr",     32'(wb_memtoreg),          32'(e_wb.mtr));
        chk("wb_dest",    32'(wb_write_destination), 32'(e_wb.dst));
        chk("wb_alu",     32'(wb_alu_output),        32'(e_wb.alu));
        chk("wb_mdata",   32'(wb_mem_data),          32'(e_wb.md));
        chk("mem_err",    32'(mem_err),              32'(e_err));
        if (stall)    stall_cnt++;
        if (pc_load)  begin pl_cnt++; last_tgt = pc_target; end
        if (dmem_req) begin seen_we = dmem_we; seen_wd = dmem_wdata; end
    endtask

    // Compare at the falling edge, then advance expectations past the rising edge.
    task automatic tick();
        @(negedge clk);
        if (chk_en) compare_cycle();
        @(posedge clk);
        #1;
        e_wb  = p_wb;
        e_err = e_err | p_err;
        p_err = 1'b0;
    endtask

    function automatic wb_t bubble_wb();
        wb_t w;
        w.rw = 1'b0; w.mtr = 1'b0; w.dst = '0; w.alu = '0; w.md = '0;
        return w;
    endfunction

    task automatic set_bus_idle();
        e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
    endtask

    // Redirect rules: jmem beats j beats a taken branch.
    task automatic pc_rule(input op_t o, input logic [DW-1:0] rd, output logic ld, output logic [DW-1:0] tg);
        ld = 1'b1;
        if (o.jm)               tg = rd;
        else if (o.jp)          tg = o.sj;
        else if (o.br && o.zf)  tg = o.ab;
        else begin ld = 1'b0;   tg = '0; end
    endtask

    task automatic apply(input op_t o);
        memread = o.mr; memwrite = o.mw; jmem = o.jm; stw = o.st; regwrite = o.rw;
        branch = o.br; j = o.jp; zero_flaf = o.zf; write_destination = o.dst;
        alu_output = o.alu; result_shift_jump = o.sj; result_adder_branch = o.ab;
        read_data2 = o.rd2; output_adder_increment_pc = o.pc1;
    endtask

    // Runs one EX/MEM instruction to retirement; cut>0 stops after that many REQ cycles.
    task automatic do_op(input op_t o, input int cut);
        logic memop, ill, acked, ld;
        logic [DW-1:0] tg;
        int n;
        memop = o.mr | o.mw | o.jm;
        ill   = o.mw & (o.mr | o.jm);
        acked = (o.wt >= 0) && (o.wt < TO);
        n     = acked ? o.wt + 1 : TO;
        apply(o);
        set_bus_idle();
        dmem_ack   = 1'($urandom_range(0, 1));
        dmem_rdata = DW'($urandom);
        if (!memop) begin
            pc_rule(o, '0, ld, tg);
            e_stall = 1'b0; e_pcl = ld; e_tgt = tg;
            p_wb.rw = o.rw; p_wb.mtr = 1'b0; p_wb.dst = o.dst; p_wb.alu = o.alu; p_wb.md = '0;
            cyc = 1;
            tick();
            return;
        end
        e_stall = 1'b1; e_pcl = 1'b0; e_tgt = '0;
        p_wb  = bubble_wb();
        p_err = ill;
        cyc   = 1;
        tick();
        for (int i = 1; i <= n; i++) begin
            if (cut > 0 && i > cut) return;
            dmem_ack   = (i == n) && acked;
            dmem_rdata = dmem_ack ? o.rdata : DW'($urandom);
            e_req = 1'b1; e_we = o.mw & ~ill; e_addr = o.alu[AW-1:0];
            e_wd  = o.st ? o.pc1 : o.rd2;
            e_stall = (i != n);
            e_pcl = 1'b0; e_tgt = '0;
            p_wb  = bubble_wb();
            if (i == n) begin
                if (acked) begin
                    pc_rule(o, o.rdata, ld, tg);
                    e_pcl = ld; e_tgt = tg;
                end else begin
                    p_err = 1'b1;
                end
                p_wb.rw = o.rw & acked; p_wb.mtr = o.mr & ~o.jm; p_wb.dst = o.dst;
                p_wb.alu = o.alu; p_wb.md = acked ? o.rdata : '0;
            end
            cyc++;
            tick();
        end
    endtask

    function automatic op_t zop();
        op_t o;
        o.mr = 0; o.mw = 0; o.jm = 0; o.st = 0; o.rw = 0; o.br = 0; o.jp = 0; o.zf = 0;
        o.dst = '0; o.alu = '0; o.sj = '0; o.ab = '0; o.rd2 = '0; o.pc1 = '0; o.rdata = '0;
        o.wt = 0;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int r;
        o = zop();
        o.st = 1'($urandom); o.rw = 1'($urandom); o.br = 1'($urandom);
        o.jp = ($urandom_range(0, 3) == 0); o.zf = 1'($urandom);
        o.dst = RW'($urandom); o.alu = DW'($urandom); o.sj = DW'($urandom);
        o.ab = DW'($urandom); o.rd2 = DW'($urandom); o.pc1 = DW'($urandom);
        o.rdata = DW'($urandom);
        if ($urandom_range(0, 9) >= 4) begin
            do begin
                o.mr = 1'($urandom); o.mw = 1'($urandom); o.jm = ($urandom_range(0, 3) == 0);
            end while (!(o.mr | o.mw | o.jm));
        end
        r = $urandom_range(0, 15);
        if (r < 11)       o.wt = $urandom_range(0, 3);
        else if (r < 13)  o.wt = TO - 1;
        else if (r == 13) o.wt = -1;
        else if (r == 14) o.wt = TO + $urandom_range(0, 2);
        else              o.wt = TO - 2;
        return o;
    endfunction

    task automatic do_reset();
        chk_en = 1'b0;
        rst = 1'b1;
        apply(zop());
        dmem_ack = 1'b0; dmem_rdata = '0;
        tick();
        rst = 1'b0;
        e_wb = bubble_wb(); p_wb = bubble_wb();
        e_err = 1'b0; p_err = 1'b0;
        set_bus_idle();
        chk_en = 1'b1;
    endtask

    initial begin
        op_t o;
        int s0, p0;
        e_wb = bubble_wb(); p_wb = bubble_wb(); e_err = 1'b0; p_err = 1'b0;
        e_stall = 1'b0; e_pcl = 1'b0; e_tgt = '0;
        set_bus_idle();
        do_reset();
        do_reset();
        chk("rst_req",   32'(dmem_req),    32'd0);
        chk("rst_err",   32'(mem_err),     32'd0);
        chk("rst_wbrw",  32'(wb_regwrite), 32'd0);

        o = zop(); o.rw = 1; o.alu = 20'h00123; o.dst = 20'd5;
        s0 = stall_cnt;
        do_op(o, 0);
        chk("alu_wb_alu",  32'(wb_alu_output),        32'h00123);
        chk("alu_wb_dest", 32'(wb_write_destination), 32'd5);
        chk("alu_wb_rw",   32'(wb_regwrite),          32'd1);
        chk("alu_stalls",  32'(stall_cnt - s0),       32'd0);

        o = zop(); o.mr = 1; o.rw = 1; o.alu = 20'h00040; o.rdata = 20'hABCDE; o.wt = 3;
        s0 = stall_cnt;
        do_op(o, 0);
        chk("ld_stalls", 32'(stall_cnt - s0), 32'd4);
        chk("ld_mdata",  32'(wb_mem_data),    32'hABCDE);
        chk("ld_mtr",    32'(wb_memtoreg),    32'd1);

        o = zop(); o.mw = 1; o.st = 1; o.pc1 = 20'h00011; o.rd2 = 20'h55555; o.wt = 0;
        do_op(o, 0);
        chk("st_cycles", 32'(cyc),     32'd2);
        chk("st_we",     32'(seen_we), 32'd1);
        chk("st_wdata",  32'(seen_wd), 32'h00011);

        o = zop(); o.br = 1; o.zf = 1; o.ab = 20'h00200;
        p0 = pl_cnt;
        do_op(o, 0);
        chk("br_pulses", 32'(pl_cnt - p0), 32'd1);
        chk("br_target", 32'(last_tgt),    32'h00200);
        o.zf = 0;
        p0 = pl_cnt;
        do_op(o, 0);
        chk("nt_pulses", 32'(pl_cnt - p0), 32'd0);

        o = zop(); o.jm = 1; o.alu = 20'h00010; o.rdata = 20'h00300; o.wt = 1;
        p0 = pl_cnt;
        do_op(o, 0);
        chk("jm_pulses", 32'(pl_cnt - p0), 32'd1);
        chk("jm_target", 32'(last_tgt),    32'h00300);

        o = zop(); o.mr = 1; o.rw = 1; o.wt = -1;
        do_op(o, 0);
        chk("to_cycles", 32'(cyc),         32'd16);
        chk("to_err",    32'(mem_err),     32'd1);
        chk("to_wbrw",   32'(wb_regwrite), 32'd0);

        o = zop(); o.mr = 1; o.rw = 1; o.wt = -1;
        do_op(o, 3);
        do_reset();
        chk("mid_req",  32'(dmem_req),    32'd0);
        chk("mid_err",  32'(mem_err),     32'd0);
        chk("mid_wbrw", 32'(wb_regwrite), 32'd0);

        for (int k = 0; k < 300; k++) begin
            if (k % 60 == 59) begin
                o = rand_op(); o.mr = 1; o.wt = -1;
                do_op(o, $urandom_range(1, 5));
                do_reset();
            end else begin
                do_op(rand_op(), 0);
            end
        end
        o = zop();
        do_op(o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
